ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_ranger_pkg.sv | 22 ++
 rtl/ultrasonic_ranger_if.sv | 23 ++
 rtl/sync_2ff.sv | 19 +
 rtl/ultrasonic_ranger_core.sv | 163 ++++++++++++++++
 rtl/ultrasonic_ranger.sv | 40 ++++
 tb/tb_ultrasonic_ranger.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/ultrasonic_ranger_pkg.sv
// Shared definitions for the ultrasonic ranger: FSM state encoding and width helpers.
package ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GAP
    } state_e;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned timer_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Bundle of the ranger's control, echo and result signals.
interface ultrasonic_ranger_if #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned CNT_W = 20
);
    logic                    en;
    logic [N_CH-1:0]         echo;
    logic [N_CH-1:0]         trig;
    logic [N_CH*CNT_W-1:0]   echo_time;
    logic [N_CH-1:0]         valid;
    logic [N_CH-1:0]         timeout;
    logic                    busy;

    modport master (
        output en, echo,
        input  trig, echo_time, valid, timeout, busy
    );

    modport slave (
        input  en, echo,
        output trig, echo_time, valid, timeout, busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/ultrasonic_ranger_core.sv
// Ranging sequencer: trigger, wait for echo, time it, then idle gap, channel by channel.
module ultrasonic_ranger_core
    import ranger_pkg::*;
#(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned TRIG_CYC = 500,
    parameter int unsigned TIMEOUT  = 1500000,
    parameter int unsigned GAP_CYC  = 3000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ultrasonic_ranger_if.slave bus
);
    localparam int unsigned    CW        = ch_w(N_CH);
    localparam int unsigned    TW        = timer_w(TIMEOUT, GAP_CYC);
    localparam logic [TW-1:0]  TRIG_LAST = TW'(TRIG_CYC - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  GAP_LAST  = TW'(GAP_CYC - 1);
    localparam logic [CW-1:0]  CH_LAST   = CW'(N_CH - 1);

    logic [N_CH-1:0] es;

    for (genvar i = 0; i < N_CH; i++) begin : g_sync
        sync_2ff u_sync (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (bus.echo[i]),
            .q_o   (es[i])
        );
    end

    state_e              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d, ch_inc;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_CH-1:0]     trig_q, trig_d;
    logic [N_CH-1:0]     valid_q, valid_d;
    logic [N_CH-1:0]     tout_q, tout_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    et_q [N_CH];
    logic [CNT_W-1:0]    et_d [N_CH];
    logic                finish_ok, finish_to;
    logic [N_CH*CNT_W-1:0] et_flat;

    assign ch_inc = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        trig_d    = trig_q;
        valid_d   = '0;
        tout_d    = tout_q;
        et_d      = et_q;
        finish_ok = 1'b0;
        finish_to = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_TRIG;
                    timer_d = '0;
                    trig_d  = N_CH'(1) << ch_q;
                end
            end
            ST_TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    trig_d  = '0;
                    state_d = ST_WAIT_RISE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                // The rise cycle itself is the first counted high cycle.
                if (es[ch_q]) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    finish_to = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!es[ch_q]) begin
                    finish_ok = 1'b1;
                end else if (timer_q == TO_LAST) begin
                    finish_to = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    ch_d    = ch_inc;
                    timer_d = '0;
                    if (bus.en) begin
                        state_d = ST_TRIG;
                        trig_d  = N_CH'(1) << ch_inc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish_ok || finish_to) begin
            et_d[ch_q]    = finish_to ? '1 : cnt_q;
            valid_d[ch_q] = 1'b1;
            tout_d[ch_q]  = finish_to;
            state_d       = ST_GAP;
            timer_d       = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            trig_q  <= '0;
            valid_q <= '0;
            tout_q  <= '0;
            busy_q  <= 1'b0;
            et_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
            et_q    <= et_d;
        end
    end

    always_comb begin
        et_flat = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            et_flat[i*CNT_W +: CNT_W] = et_q[i];
        end
    end

    assign bus.trig      = trig_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = tout_q;
    assign bus.busy      = busy_q;
    assign bus.echo_time = et_flat;
endmodule

// File: rtl/ultrasonic_ranger.sv
// Multi-channel ultrasonic ranger top: flat ports bridged onto the internal bus.
module ultrasonic_ranger #(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned CNT_W    = 20,
    parameter int unsigned TRIG_CYC = 500,
    parameter int unsigned TIMEOUT  = 1500000,
    parameter int unsigned GAP_CYC  = 3000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH-1:0]       echo,
    output logic [N_CH-1:0]       trig,
    output logic [N_CH*CNT_W-1:0] echo_time,
    output logic [N_CH-1:0]       valid,
    output logic [N_CH-1:0]       timeout,
    output logic                  busy
);
    ultrasonic_ranger_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    assign bus.en    = en;
    assign bus.echo  = echo;
    assign trig      = bus.trig;
    assign echo_time = bus.echo_time;
    assign valid     = bus.valid;
    assign timeout   = bus.timeout;
    assign busy      = bus.busy;

    ultrasonic_ranger_core #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .TRIG_CYC (TRIG_CYC),
        .TIMEOUT  (TIMEOUT),
        .GAP_CYC  (GAP_CYC)
    ) u_core (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger: directed table, randomized pings, reset cases.
module tb_ultrasonic_ranger;
    localparam int N_CH = 3, CNT_W = 8, TRIG_CYC = 4, TIMEOUT = 50, GAP_CYC = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ultrasonic_ranger_if #(.N_CH(N_CH), .CNT_W(CNT_W)) rif ();

    ultrasonic_ranger #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYC(TRIG_CYC), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .en(rif.en), .echo(rif.echo), .trig(rif.trig),
        .echo_time(rif.echo_time), .valid(rif.valid), .timeout(rif.timeout), .busy(rif.busy)
    );

    typedef struct {
        int         c;
        int         d;
        int         w;
        bit         noise;
        logic [7:0] et;
        bit         to;
    } vec_t;

    int checks = 0, failures = 0, cyc = 0, last_v = 0, exp_ch = 0;
    logic [CNT_W-1:0] mdl_et [N_CH];
    logic [N_CH-1:0]  mdl_to;
    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CNT_W-1:0] et_of(input int c);
        logic [N_CH*CNT_W-1:0] v;
        v = rif.echo_time;
        return v[c*CNT_W +: CNT_W];
    endfunction

    // d: cycles after trig falls that the raw echo rises; w: raw high length (0 = no echo).
    // The synchroniser plus the FSM sampling edge put a rise 3 cycles late.
    // lat: cycles from trig falling until valid is seen.
    function automatic void model(input int d, input int w,
                                  output logic [7:0] et, output bit to, output int lat);
        if (w == 0 || d + 3 > TIMEOUT) begin
            et = '1; to = 1'b1; lat = TIMEOUT;
        end else if (w > TIMEOUT) begin
            et = '1; to = 1'b1; lat = d + 3 + TIMEOUT;
        end else begin
            et = 8'(w); to = 1'b0; lat = d + 3 + w;
        end
    endfunction

    task automatic run_ping(input int c, input int d, input int w, input bit noise,
                            input bit gap_chk, input bit drop_en,
                            input logic [7:0] xet, input bit xto);
        logic [7:0] m_et;
        bit m_to, seen;
        int lat, n, hi;
        model(d, w, m_et, m_to, lat);
        n = 0;
        while (rif.trig === '0 && n < 300) begin tick(); n++; end
        check("trig_start_in_budget", n < 300, 1);
        if (n >= 300) return;
        check("trig_onehot", rif.trig, 64'(1) << c);
        if (gap_chk) check("gap_spacing", cyc - last_v, GAP_CYC);
        if (drop_en) rif.en = 1'b0;
        hi = 0;
        while (rif.trig !== '0 && hi < 100) begin tick(); hi++; end
        check("trig_len", hi, TRIG_CYC);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            for (int j = 0; j < N_CH; j++)
                rif.echo[j] = (j == c) ? (w > 0 && k >= d && k < d + w)
                                       : (noise ? 1'($urandom % 2) : 1'b0);
            tick();
            if (rif.valid !== '0) begin
                seen = 1'b1;
                check("valid_latency", k + 1, lat);
                check("valid_channel", rif.valid, 64'(1) << c);
                check("echo_time", et_of(c), xet);
                check("timeout_bit", rif.timeout[c], xto);
                mdl_et[c] = xet;
                mdl_to[c] = xto;
                for (int j = 0; j < N_CH; j++)
                    if (j != c) check("other_echo_time_held", et_of(j), mdl_et[j]);
                check("timeout_vector", rif.timeout, mdl_to);
            end
        end
        check("valid_seen", seen, 1);
        rif.echo = '0;
        last_v = cyc;
        tick();
        check("valid_single_pulse", rif.valid, 0);
        exp_ch = (c + 1) % N_CH;
    endtask

    initial begin
        logic [7:0] r_et;
        bit r_to, any;
        int r_lat, r_d, r_w, n;

        tbl[0] = '{0,  5, 20, 1'b0, 8'd20,  1'b0};
        tbl[1] = '{1,  0,  0, 1'b0, 8'd255, 1'b1};
        tbl[2] = '{2,  3, 70, 1'b0, 8'd255, 1'b1};
        tbl[3] = '{0, 10,  1, 1'b1, 8'd1,   1'b0};
        tbl[4] = '{1,  2, 33, 1'b0, 8'd33,  1'b0};
        tbl[5] = '{2, 47,  5, 1'b0, 8'd5,   1'b0};
        tbl[6] = '{0, 48,  5, 1'b0, 8'd255, 1'b1};
        tbl[7] = '{1,  1, 50, 1'b0, 8'd50,  1'b0};
        tbl[8] = '{2,  1, 51, 1'b1, 8'd255, 1'b1};

        for (int i = 0; i < N_CH; i++) mdl_et[i] = '0;
        mdl_to = '0;
        rst = 1'b1; rif.en = 1'b0; rif.echo = '0;
        tick(); tick();
        check("rst_trig", rif.trig, 0);
        check("rst_valid", rif.valid, 0);
        check("rst_timeout", rif.timeout, 0);
        check("rst_busy", rif.busy, 0);
        check("rst_echo_time", rif.echo_time, 0);
        rst = 1'b0;
        tick(); tick();
        check("idle_without_en", rif.busy, 0);

        rif.en = 1'b1;
        for (int i = 0; i < 9; i++)
            run_ping(tbl[i].c, tbl[i].d, tbl[i].w, tbl[i].noise, i > 0, 1'b0, tbl[i].et, tbl[i].to);

        for (int i = 0; i < 12; i++) begin
            r_d = $urandom_range(1, 55);
            r_w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
            model(r_d, r_w, r_et, r_to, r_lat);
            run_ping(exp_ch, r_d, r_w, 1'($urandom % 2), 1'b1, 1'b0, r_et, r_to);
        end

        // en dropped during a ping: the ping completes, the gap runs out, then idle.
        run_ping(exp_ch, 4, 10, 1'b0, 1'b1, 1'b1, 8'd10, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("busy_through_gap", rif.busy, 1);
        tick();
        check("idle_after_gap", rif.busy, 0);
        any = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); any |= (rif.trig != '0) || rif.busy; end
        check("stays_idle", any, 0);

        // Reset while measuring.
        rif.en = 1'b1;
        n = 0;
        while (rif.trig === '0 && n < 300) begin tick(); n++; end
        check("rst_case_trig_onehot", rif.trig, 64'(1) << exp_ch);
        n = 0;
        while (rif.trig !== '0 && n < 100) begin tick(); n++; end
        rif.echo[exp_ch] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("busy_in_measure", rif.busy, 1);
        rst = 1'b1;
        tick();
        check("midrst_trig", rif.trig, 0);
        check("midrst_valid", rif.valid, 0);
        check("midrst_timeout", rif.timeout, 0);
        check("midrst_busy", rif.busy, 0);
        check("midrst_echo_time", rif.echo_time, 0);
        rst = 1'b0; rif.en = 1'b0; rif.echo = '0;
        any = 1'b0;
        for (int i = 0; i < 60; i++) begin tick(); any |= (rif.valid != '0) || rif.busy; end
        check("no_valid_after_rst", any, 0);

        for (int i = 0; i < N_CH; i++) mdl_et[i] = '0;
        mdl_to = '0;
        rif.en = 1'b1;
        run_ping(0, 5, 7, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
